axil_sram: RTL and testbench

AXI4-Lite memory responder on the far side of `arbiter`: it services the read (AR/R) and write (AW/W/B) channels that `ifu` and `lsu` drive as initiators. Accepted accesses become `n_pmem_read` / `n_pmem_write` DPI calls into simulated physical memory. Each response is returned after a programmable latency, with SLVERR for out-of-range addresses. Read and write channels run as independent state machines.

---
 rtl/axil_pkg.sv | 35 +++
 rtl/axil_sram_if.sv | 39 +++
 rtl/axil_lat_cnt.sv | 28 ++
 rtl/axil_sram.sv | 257 +++++++++++++++++++++++++
 tb/tb_axil_sram.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes, FSM states and address-range helper
// Purpose: common definitions for the AXI4-Lite responder and its initiators.
// Ports: none (package).
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  // True when base <= addr < base+size. The sum is taken in 33 bits so a
  // window ending at the top of the address space does not wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/axil_sram_if.sv
// rtl/axil_sram_if.sv - AXI4-Lite read/write channel bundle
// Purpose: groups the AR/R/AW/W/B channel signals of one AXI4-Lite link.
// Ports: none; modport master drives requests (initiator), modport slave
//        drives readys and responses (responder).
interface axil_sram_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axil_lat_cnt.sv
// rtl/axil_lat_cnt.sv - 4-bit latency down-counter
// Purpose: counts response latency for one channel.
// Ports: clk, rst (async active-low), load/load_val (preset), dec (count
//        down, saturating at 0), done (count is 0).
module axil_lat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd0);

endmodule

// File: rtl/axil_sram.sv
// rtl/axil_sram.sv - AXI4-Lite memory responder with programmable latency
// Purpose: services AXI4-Lite reads and writes against a physical-memory
//          port; out-of-window addresses answer SLVERR with no memory access.
// Ports: clk, rst (async active-low); bus (AXI4-Lite slave side);
//        pmem_ren/pmem_raddr/pmem_rdata: one-cycle read request, data
//        returned combinationally and latched on the same edge;
//        pmem_wen/pmem_waddr/pmem_wdata/pmem_wmask: one-cycle write request,
//        committed by the memory on the same edge.
module axil_sram
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE          = 32'h8000_0000,
  parameter logic [31:0] SIZE          = 32'h0800_0000,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  axil_sram_if.slave  bus,
  output logic        pmem_ren,
  output logic [31:0] pmem_raddr,
  input  logic [31:0] pmem_rdata,
  output logic        pmem_wen,
  output logic [31:0] pmem_waddr,
  output logic [31:0] pmem_wdata,
  output logic [7:0]  pmem_wmask
);

  // The counter is preset at the handshake edge and the FSM leaves WAIT on
  // the edge where it reads 0, so LATENCY-2 gives exactly LATENCY cycles.
  localparam logic [3:0] R_LOAD = (READ_LATENCY >= 2)  ? 4'(READ_LATENCY - 2)  : 4'd0;
  localparam logic [3:0] W_LOAD = (WRITE_LATENCY >= 2) ? 4'(WRITE_LATENCY - 2) : 4'd0;

  // Readys are held low until the first edge after reset release.
  logic live;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live <= 1'b0;
    else      live <= 1'b1;
  end

  // ---------------- read channel ----------------
  r_state_t    r_state;
  r_state_t    r_next;
  logic        r_load;
  logic        r_dec;
  logic        r_done;
  logic        ar_hs;
  logic [31:2] ar_addr_q;
  logic [31:0] r_word;
  logic        r_ok;
  logic        r_enter;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] rd_word;

  assign ar_hs = bus.arvalid && bus.arready;

  axil_lat_cnt u_r_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (r_load),
    .load_val (R_LOAD),
    .dec      (r_dec),
    .done     (r_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    r_load = 1'b0;
    r_dec  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          if (READ_LATENCY <= 1) begin
            r_next = R_RESP;
          end else begin
            r_next = R_WAIT;
            r_load = 1'b1;
          end
        end
      end
      R_WAIT: begin
        if (r_done) r_next = R_RESP;
        else        r_dec  = 1'b1;
      end
      R_RESP: begin
        if (bus.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ar_addr_q <= '0;
    else if (ar_hs) ar_addr_q <= bus.araddr[31:2];
  end

  // With latency 1 the response is entered on the handshake edge itself,
  // before the address register has captured, so use the live bus value.
  assign r_word  = {(ar_hs ? bus.araddr[31:2] : ar_addr_q), 2'b00};
  assign r_ok    = addr_in_range(r_word, BASE, SIZE);
  assign r_enter = (r_next == R_RESP) && (r_state != R_RESP);

  // ---------------- write channel ----------------
  w_state_t    w_state;
  w_state_t    w_next;
  logic        w_load;
  logic        w_dec;
  logic        w_done;
  logic        flags_clr;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_got;
  logic        w_got;
  logic [31:2] aw_addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] w_word;
  logic [31:0] w_data_cur;
  logic [3:0]  w_strb_cur;
  logic        w_ok;
  logic        w_enter;
  logic [1:0]  bresp_q;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;

  axil_lat_cnt u_w_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (W_LOAD),
    .dec      (w_dec),
    .done     (w_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  // Leave IDLE on the edge where the second of AW/W lands (including the
  // same-cycle case) so the latency is counted from that handshake.
  always_comb begin
    w_next    = w_state;
    w_load    = 1'b0;
    w_dec     = 1'b0;
    flags_clr = 1'b0;
    case (w_state)
      W_IDLE: begin
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          flags_clr = 1'b1;
          if (WRITE_LATENCY <= 1) begin
            w_next = W_RESP;
          end else begin
            w_next = W_WAIT;
            w_load = 1'b1;
          end
        end
      end
      W_WAIT: begin
        if (w_done) w_next = W_RESP;
        else        w_dec  = 1'b1;
      end
      W_RESP: begin
        if (bus.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (flags_clr) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (aw_hs) aw_addr_q <= bus.awaddr[31:2];
      if (w_hs) begin
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb[3:0];
      end
    end
  end

  assign w_word     = {(aw_hs ? bus.awaddr[31:2] : aw_addr_q), 2'b00};
  assign w_data_cur = w_hs ? bus.wdata : wdata_q;
  assign w_strb_cur = w_hs ? bus.wstrb[3:0] : wstrb_q;
  assign w_ok       = addr_in_range(w_word, BASE, SIZE);
  assign w_enter    = (w_next == W_RESP) && (w_state != W_RESP);

  // ---------------- memory port ----------------
  assign pmem_ren   = r_enter && r_ok;
  assign pmem_raddr = r_word;
  assign pmem_wen   = w_enter && w_ok;
  assign pmem_waddr = w_word;
  assign pmem_wdata = w_data_cur;
  assign pmem_wmask = {4'b0000, w_strb_cur};

  // The memory returns pre-write contents on a same-edge read/write, so the
  // enabled write bytes are forwarded here: the write is ordered first.
  always_comb begin
    rd_word = pmem_rdata;
    if (pmem_wen && pmem_ren && (pmem_waddr == pmem_raddr)) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_cur[b]) rd_word[8*b +: 8] = w_data_cur[8*b +: 8];
      end
    end
  end

  // Response payloads are captured once, on entry to RESP, and held through
  // any amount of rready/bready backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
      bresp_q <= OKAY;
    end else begin
      if (r_enter) begin
        rdata_q <= r_ok ? rd_word : 32'h0;
        rresp_q <= r_ok ? OKAY : SLVERR;
      end
      if (w_enter) begin
        bresp_q <= w_ok ? OKAY : SLVERR;
      end
    end
  end

  assign bus.arready = live && (r_state == R_IDLE);
  assign bus.rvalid  = (r_state == R_RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = live && (w_state == W_IDLE) && !aw_got;
  assign bus.wready  = live && (w_state == W_IDLE) && !w_got;
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.bresp   = bresp_q;

  // Sub-word address bits and the upper strobe nibble carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{bus.wstrb[7:4], bus.araddr[1:0], bus.awaddr[1:0]};

endmodule

// File: tb/tb_axil_sram.sv
// tb/tb_axil_sram.sv - scoreboard bench for axil_sram
module tb_axil_sram;

  localparam int RL = 4;
  localparam int WL = 1;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pmem_ren;
  logic [31:0] pmem_raddr;
  logic [31:0] pmem_rdata;
  logic        pmem_wen;
  logic [31:0] pmem_waddr;
  logic [31:0] pmem_wdata;
  logic [7:0]  pmem_wmask;

  axil_sram_if bus ();

  axil_sram #(
    .BASE          (32'h8000_0000),
    .SIZE          (32'h0800_0000),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .pmem_ren   (pmem_ren),
    .pmem_raddr (pmem_raddr),
    .pmem_rdata (pmem_rdata),
    .pmem_wen   (pmem_wen),
    .pmem_waddr (pmem_waddr),
    .pmem_wdata (pmem_wdata),
    .pmem_wmask (pmem_wmask)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_calls = 0;
  int wr_calls = 0;

  logic [33:0] rq[$];
  logic [1:0]  bq[$];
  logic [33:0] r_e;
  logic [1:0]  b_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Physical memory model: 256 words, word index from address bits [9:2].
  logic [31:0] mem [0:255];
  bit          mem_ready = 1'b0;

  assign pmem_rdata = mem[pmem_raddr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem_ready <= 1'b1;
    end else if (pmem_wen) begin
      for (int b = 0; b < 4; b++)
        if (pmem_wmask[b]) mem[pmem_waddr[9:2]][8*b +: 8] <= pmem_wdata[8*b +: 8];
    end
    if (pmem_ren) rd_calls <= rd_calls + 1;
    if (pmem_wen) wr_calls <= wr_calls + 1;
  end

  // Response monitor: pops the scoreboard on every R/B handshake.
  always @(negedge clk) begin
    if (pmem_wen) chk("wmask_hi", 64'(pmem_wmask[7:4]), 64'd0);
    if (bus.rvalid && bus.rready) begin
      if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
      else begin
        r_e = rq.pop_front();
        chk("rdata", 64'(bus.rdata), 64'(r_e[31:0]));
        chk("rresp", 64'(bus.rresp), 64'(r_e[33:32]));
      end
    end
    if (bus.bvalid && bus.bready) begin
      if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
      else begin
        b_e = bq.pop_front();
        chk("bresp", 64'(bus.bresp), 64'(b_e));
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_d,
                         input logic [1:0] exp_r, input int stall);
    int t_hs;
    int n;
    int c0;
    bit ok;
    t_hs = 0;
    @(posedge clk); #1;
    rq.push_back({exp_r, exp_d});
    c0 = rd_calls;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (bus.arready) begin ok = 1'b1; t_hs = cyc; end
      @(posedge clk); #1; n++;
    end
    bus.arvalid = 1'b0;
    if (!ok) begin chk("ar_timeout", 64'd0, 64'd1); void'(rq.pop_back()); return; end
    ok = 1'b0; n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (bus.rvalid) ok = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    if (!ok) begin chk("r_timeout", 64'd0, 64'd1); void'(rq.pop_back()); return; end
    chk("r_latency", 64'(cyc - t_hs), 64'(RL));
    for (int i = 0; i < stall; i++) begin
      chk("r_hold_data", 64'(bus.rdata), 64'(exp_d));
      chk("r_hold_valid", 64'(bus.rvalid), 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.rready = 1'b0;
    @(negedge clk);
    chk("ar_turnaround", 64'(bus.arready), 64'd1);
    chk("rd_calls", 64'(rd_calls - c0), (exp_r == OK) ? 64'd1 : 64'd0);
  endtask

  // W is presented first; AW follows w_lead cycles later (0 = same cycle).
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [7:0] strb, input int w_lead,
                          input logic [1:0] exp_r);
    int t_hs;
    int n;
    int c0;
    bit aw_ok;
    bit w_ok;
    bit ok;
    t_hs = 0;
    @(posedge clk); #1;
    bq.push_back(exp_r);
    c0 = wr_calls;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    bus.awaddr  = addr;
    bus.awvalid = (w_lead == 0);
    aw_ok = 1'b0; w_ok = 1'b0; n = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      @(negedge clk);
      if (bus.awvalid && bus.awready) begin aw_ok = 1'b1; t_hs = cyc; end
      if (bus.wvalid && bus.wready)   begin w_ok  = 1'b1; t_hs = cyc; end
      @(posedge clk); #1; n++;
      if (aw_ok) bus.awvalid = 1'b0;
      if (w_ok)  bus.wvalid  = 1'b0;
      if (!aw_ok && n >= w_lead) bus.awvalid = 1'b1;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_ok && w_ok)) begin chk("aw_w_timeout", 64'd0, 64'd1); void'(bq.pop_back()); return; end
    ok = 1'b0; n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (bus.bvalid) ok = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    if (!ok) begin chk("b_timeout", 64'd0, 64'd1); void'(bq.pop_back()); return; end
    chk("b_latency", 64'(cyc - t_hs), 64'(WL));
    @(posedge clk); #1;
    bus.bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.bready = 1'b0;
    @(negedge clk);
    chk("aw_w_turnaround", 64'({bus.awready, bus.wready}), 64'd3);
    chk("wr_calls", 64'(wr_calls - c0), (exp_r == OK) ? 64'd1 : 64'd0);
  endtask

  int rc0;
  int wc0;

  initial begin
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;

    // Reset state and ready release timing.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({bus.arready, bus.awready, bus.wready, bus.rvalid,
                              bus.bvalid, bus.rresp, bus.bresp, bus.rdata}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", 64'({bus.arready, bus.awready, bus.wready}), 64'd0);
    @(negedge clk);
    chk("ready_after_edge", 64'({bus.arready, bus.awready, bus.wready}), 64'd7);

    // Write then read, unaligned read address.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, OK);
    do_read (32'h8000_0013, 32'hDEAD_BEEF, OK, 0);

    // W three cycles ahead of AW; only the low two bytes are enabled.
    do_write(32'h8000_0010, 32'h1122_3344, 8'hF3, 3, OK);
    do_read (32'h8000_0010, 32'hDEAD_3344, OK, 0);

    // Window boundaries.
    do_read (32'h7FFF_FFFC, 32'h0, SE, 0);
    do_write(32'h8800_0000, 32'h1234_5678, 8'h0F, 0, SE);
    do_read (32'h87FF_FFFF, 32'hA5A5_00FF, OK, 0);

    // Read backpressure with data held stable.
    do_read (32'h8000_0010, 32'hDEAD_3344, OK, 5);

    // Read and write to the same word both enter their response on one edge.
    @(posedge clk); #1;
    rc0 = rd_calls; wc0 = wr_calls;
    rq.push_back({OK, 32'hCAFE_F00D});
    bq.push_back(OK);
    bus.araddr = 32'h8000_0020; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("col_arready", 64'(bus.arready), 64'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.awaddr = 32'h8000_0020; bus.awvalid = 1'b1;
    bus.wdata = 32'hCAFE_F00D; bus.wstrb = 8'h0F; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(negedge clk);
    chk("col_valids", 64'({bus.rvalid, bus.bvalid}), 64'd3);
    @(posedge clk); #1;
    bus.rready = 1'b0; bus.bready = 1'b0;
    @(negedge clk);
    chk("col_calls", 64'({16'(rd_calls - rc0), 16'(wr_calls - wc0)}), 64'h0001_0001);

    // Reset during R_WAIT with AW captured and W still pending.
    @(posedge clk); #1;
    rc0 = rd_calls; wc0 = wr_calls;
    bus.araddr = 32'h8000_0010; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.awaddr = 32'h8000_0010; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", 64'({bus.arready, bus.awready, bus.wready, bus.rvalid,
                               bus.bvalid, bus.rresp, bus.bresp, bus.rdata}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_readys", 64'({bus.arready, bus.awready, bus.wready}), 64'd7);
    chk("midrst_calls", 64'({16'(rd_calls - rc0), 16'(wr_calls - wc0)}), 64'd0);
    do_read (32'h8000_0010, 32'hDEAD_3344, OK, 0);

    repeat (2) @(negedge clk);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("bq_drained", 64'(bq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
